axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder register file. It is the far end of the UART bridge's AXI4-Lite master and terminates its single-beat transactions.
- Provides N_RW software-writable control registers, exported to fabric, plus read-only status registers sampled from fabric.
- Write and read channels run independently, each with its own FSM. Decode errors return SLVERR so the bridge can report its AXI_SLVERR status.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr decoded (word index = addr[ADDR_WIDTH-1:2])
N_REGS, 16, total 32-bit registers mapped at word indices 0..N_REGS-1 (2..64)
N_RW, 8, indices 0..N_RW-1 are read/write; N_RW..N_REGS-1 are read-only (1..N_REGS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
axi  slave modport  axi4_lite_if  aw*/w*/b*/ar*/r* channels, 32-bit data, 4-bit wstrb
reg_out  out  N_RW*32  control register contents, reg i at [i*32 +: 32]
reg_wr_pulse  out  N_RW  one-cycle pulse when reg i is committed by a successful write
status_in  in  (N_REGS-N_RW)*32  read-only values; index N_RW+k at [k*32 +: 32]

Behaviour:
Reset (rst=0, asynchronous):
- All reg_out = 0, reg_wr_pulse = 0, bvalid = 0, rvalid = 0, bresp = rresp = 00, rdata = 0.
- Held AW/W captures are cleared. Both FSMs go to IDLE.
- awready, wready and arready are forced 0 combinationally while rst = 0.

Decode (both channels):
- idx = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored, and byte selection comes from wstrb only.
- Write error if idx >= N_REGS or idx >= N_RW. Read error if idx >= N_REGS. awprot/arprot are ignored.

Write FSM, states WR_IDLE and WR_RESP:
- WR_IDLE:
  - awready = !aw_held; wready = !w_held.
  - An AW handshake latches awaddr into aw_held; a W handshake latches wdata/wstrb into w_held.
  - AW and W may arrive in either order or in the same cycle.
  - On the edge where both are available (held or handshaking that cycle):
    - Valid index: byte lane b of reg[idx] is updated only where wstrb[b] = 1; reg_wr_pulse[idx] = 1 for exactly the next cycle; bresp = 00.
    - Error: no register change, no pulse, bresp = 10.
    - Both holds clear, bvalid = 1, and the FSM moves to WR_RESP.
  - Latency: AW and W in the same cycle T gives bvalid high at T+1.
- WR_RESP:
  - awready = wready = 0. bvalid and bresp stay stable until bready = 1.
  - On the B handshake: bvalid = 0 and the FSM returns to WR_IDLE. A new AW/W is accepted from the following cycle.

Read FSM, states RD_IDLE and RD_RESP:
- RD_IDLE: arready = 1. On an AR handshake, rdata/rresp are registered and rvalid = 1 on the next cycle.
  - Valid index: rdata = reg[idx] or the status word, rresp = 00.
  - Error: rdata = 0, rresp = 10.
- RD_RESP: arready = 0. rvalid, rdata and rresp stay stable until rready = 1, then rvalid = 0 and the FSM returns to RD_IDLE.
- rdata is sampled at the AR edge, so later status_in changes do not alter a pending response.

Simultaneous events:
- A read and a write committing to the same index on the same edge: the read returns the pre-write value.
- The write and read channels never stall each other.

Reset mid-operation: pending transactions are discarded with no response generated. The master observes this as a timeout.

Optional Feature:
- Macro AXI_SLV_ERRCNT_EN.
- Defined:
  - Adds output port err_count (out, 16): saturating count of SLVERR responses (write + read), counted at each B/R handshake carrying resp = 10.
  - Reset value 0. Holds at 0xFFFF when saturated.
  - A successful write of any value to index 0 with wstrb[3] = 1 and wdata[31] = 1 clears the counter. The reg 0 update still occurs.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
1. AW addr 0x04 and W 0xDEADBEEF with wstrb 0xF in the same cycle, bready = 1 -> bvalid one cycle later, bresp 00, reg_out[63:32] = 0xDEADBEEF, reg_wr_pulse = 8'b0000_0010 for one cycle.
2. W (0x0000AB00, wstrb 0x2) presented 3 cycles before AW addr 0x05, with reg1 = 0xDEADBEEF -> wready drops after the W handshake; bresp 00; reg1 = 0xDEADABEF.
3. Write to 0x20 (idx 8, read-only), then to 0x40 (idx 16, unmapped) -> both bresp 10, no reg_out change, no pulse; read of 0x40 -> rresp 10, rdata 0.
4. status_in word 1 = 0x12345678; AR to 0x24 with rready low for 5 cycles; status_in changes meanwhile -> rvalid held, rdata stays 0x12345678, arready 0 until the R handshake.
5. bready low for 10 cycles after a write, with a second AW/W pending -> awready and wready stay 0 until the B handshake, then the second write completes normally; a read issued during the stall completes unaffected.
6. rst driven low while in WR_RESP and RD_RESP -> bvalid and rvalid drop immediately, reg_out = 0; after release, a write of 0x1 to 0x00 succeeds with bresp 00.

Source files
------------

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite channel bundle (32-bit data, 4-bit strobe) between the UART bridge master and register slaves.
// Pure wiring: no state, no latency; flow control is plain valid/ready on each channel.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register file: N_RW control regs + read-only status words; AXI_SLV_ERRCNT_EN adds a SLVERR counter.
// Latency: B and R valid one cycle after the completing AW/W or AR handshake.
// Backpressure: one outstanding B and one outstanding R; channel readies stay low until that response is taken.
module axi4_lite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_REGS     = 16,
    parameter int N_RW       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    axi4_lite_if.slave                 axi,
    output logic [N_RW*32-1:0]          reg_out,
    output logic [N_RW-1:0]             reg_wr_pulse,
    input  logic [(N_REGS-N_RW)*32-1:0] status_in
`ifdef AXI_SLV_ERRCNT_EN
    ,
    output logic [15:0]                 err_count
`endif
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] N_RW_I   = IDX_W'(N_RW);
    localparam logic [IDX_W-1:0] N_REGS_I = IDX_W'(N_REGS);

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    logic [0:0]            wr_state;
    logic [0:0]            rd_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;
    logic [31:0]           rdata_q;
    logic [31:0]           regs [N_RW];
    logic [31:0]           word_map [N_REGS];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_err;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;
    logic [31:0]           rd_word;
    logic                  unused_bits;

    // Readies are gated by rst so nothing is accepted while reset is asserted.
    assign axi.awready = rst && (wr_state == WR_IDLE) && !aw_held;
    assign axi.wready  = rst && (wr_state == WR_IDLE) && !w_held;
    assign axi.arready = rst && (rd_state == RD_IDLE);
    assign axi.bvalid  = (wr_state == WR_RESP);
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (rd_state == RD_RESP);
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;

    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign ar_hs   = axi.arvalid && axi.arready;
    assign wr_addr = aw_held ? aw_addr_q : axi.awaddr;
    assign wr_data = w_held ? w_data_q : axi.wdata;
    assign wr_strb = w_held ? w_strb_q : axi.wstrb;
    assign commit  = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = wr_addr[ADDR_WIDTH-1:2];
    assign wr_err  = (wr_idx >= N_RW_I);
    assign rd_idx  = axi.araddr[ADDR_WIDTH-1:2];
    assign rd_err  = (rd_idx >= N_REGS_I);

    assign unused_bits = ^{axi.awprot, axi.arprot, wr_addr[1:0], axi.araddr[1:0]};

    for (genvar g = 0; g < N_REGS; g++) begin : g_map
        if (g < N_RW) begin : g_rw
            assign word_map[g]         = regs[g];
            assign reg_out[g*32 +: 32] = regs[g];
        end else begin : g_ro
            assign word_map[g] = status_in[(g-N_RW)*32 +: 32];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = word_map[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state     <= WR_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bresp_q      <= 2'b00;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (commit) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bresp_q  <= wr_err ? 2'b10 : 2'b00;
                        wr_state <= WR_RESP;
                        if (!wr_err) reg_wr_pulse <= N_RW'(1) << wr_idx;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= axi.awaddr;
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= axi.wdata;
                            w_strb_q <= axi.wstrb;
                        end
                    end
                end
                default: begin
                    if (axi.bready) wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_RW; i++) regs[i] <= '0;
        end else if (commit && !wr_err) begin
            for (int i = 0; i < N_RW; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data is captured at the AR edge, so it reflects pre-write register state on a same-edge commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rdata_q  <= rd_word;
                        rresp_q  <= rd_err ? 2'b10 : 2'b00;
                        rd_state <= RD_RESP;
                    end
                end
                default: begin
                    if (axi.rready) rd_state <= RD_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_SLV_ERRCNT_EN
    logic        b_err;
    logic        r_err;
    logic        cnt_clr;
    logic [16:0] err_sum;

    assign b_err   = axi.bvalid && axi.bready && (bresp_q == 2'b10);
    assign r_err   = axi.rvalid && axi.rready && (rresp_q == 2'b10);
    assign cnt_clr = commit && !wr_err && (wr_idx == '0) && wr_strb[3] && wr_data[31];
    assign err_sum = {1'b0, err_count} + 17'(b_err) + 17'(r_err);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (err_sum[16]) begin
            err_count <= 16'hFFFF;
        end else begin
            err_count <= err_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed self-checking bench for axi4_lite_reg_slave: latency, byte strobes, decode errors, stalls, reset.
module tb_axi4_lite_reg_slave;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr_pulse;
    logic [255:0] status_in;
`ifdef AXI_SLV_ERRCNT_EN
    logic [15:0]  err_count;
`endif

    int           checks   = 0;
    int           failures = 0;
    logic [255:0] exp_out;
    logic [1:0]   resp;
    logic [7:0]   pulse;
    logic [31:0]  rd;
    logic [1:0]   rr;

    axi4_lite_if #(.ADDR_WIDTH(32)) bus ();

    always #5 clk = ~clk;

    axi4_lite_reg_slave #(
        .ADDR_WIDTH(32),
        .N_REGS    (16),
        .N_RW      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi         (bus),
        .reg_out     (reg_out),
        .reg_wr_pulse(reg_wr_pulse),
        .status_in   (status_in)
`ifdef AXI_SLV_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] b_resp, output logic [7:0] b_pulse);
        logic aw_hit;
        logic w_hit;
        logic done;
        done    = 1'b0;
        b_resp  = 2'bxx;
        b_pulse = 8'hxx;
        @(negedge clk);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        for (int n = 0; n < 40 && (bus.awvalid || bus.wvalid); n++) begin
            aw_hit = bus.awvalid && bus.awready;
            w_hit  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_hit) bus.awvalid = 1'b0;
            if (w_hit)  bus.wvalid  = 1'b0;
        end
        check("wr_accept_timeout", {bus.awvalid, bus.wvalid}, 0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (bus.bvalid) begin
                b_resp  = bus.bresp;
                b_pulse = reg_wr_pulse;
                done    = 1'b1;
            end
            @(negedge clk);
        end
        check("wr_resp_timeout", done, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] r_data, output logic [1:0] r_resp);
        logic ar_hit;
        logic done;
        done   = 1'b0;
        r_data = 'x;
        r_resp = 2'bxx;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        for (int n = 0; n < 40 && bus.arvalid; n++) begin
            ar_hit = bus.arready;
            @(negedge clk);
            if (ar_hit) bus.arvalid = 1'b0;
        end
        check("rd_accept_timeout", bus.arvalid, 0);
        bus.arvalid = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (bus.rvalid) begin
                r_data = bus.rdata;
                r_resp = bus.rresp;
                done   = 1'b1;
            end
            @(negedge clk);
        end
        check("rd_resp_timeout", done, 1);
    endtask

    initial begin
        rst         = 1'b0;
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b1;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.rready  = 1'b1;
        status_in   = '0;
        exp_out     = '0;

        #12;
        check("rst_reg_out", reg_out, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: AW and W together, response one cycle later
        @(negedge clk);
        bus.awaddr  = 32'h04;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hDEADBEEF;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        check("t1_ready", {bus.awready, bus.wready}, 2'b11);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        exp_out[63:32] = 32'hDEADBEEF;
        check("t1_bvalid", bus.bvalid, 1);
        check("t1_bresp", bus.bresp, 2'b00);
        check("t1_reg_out", reg_out, exp_out);
        check("t1_pulse", reg_wr_pulse, 8'b0000_0010);
        @(negedge clk);
        check("t1_bvalid_clr", bus.bvalid, 0);
        check("t1_pulse_clr", reg_wr_pulse, 0);

        // 2: W three cycles ahead of AW, byte-lane update
        bus.wdata  = 32'h0000AB00;
        bus.wstrb  = 4'h2;
        bus.wvalid = 1'b1;
        check("t2_wready", bus.wready, 1);
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("t2_wready_drop", bus.wready, 0);
        repeat (2) @(negedge clk);
        check("t2_wready_held", bus.wready, 0);
        check("t2_no_bvalid", bus.bvalid, 0);
        bus.awaddr  = 32'h05;
        bus.awvalid = 1'b1;
        check("t2_awready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        exp_out[63:32] = 32'hDEADABEF;
        check("t2_bvalid", bus.bvalid, 1);
        check("t2_bresp", bus.bresp, 2'b00);
        check("t2_reg_out", reg_out, exp_out);
        check("t2_pulse", reg_wr_pulse, 8'b0000_0010);
        @(negedge clk);
        check("t2_wready_back", bus.wready, 1);

        // 3: decode errors
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("t3_ro_bresp", resp, 2'b10);
        check("t3_ro_pulse", pulse, 0);
        check("t3_ro_reg_out", reg_out, exp_out);
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("t3_unmap_bresp", resp, 2'b10);
        check("t3_unmap_pulse", pulse, 0);
        check("t3_unmap_reg_out", reg_out, exp_out);
        do_read(32'h40, rd, rr);
        check("t3_rd_rresp", rr, 2'b10);
        check("t3_rd_rdata", rd, 0);
`ifdef AXI_SLV_ERRCNT_EN
        check("t3_err_count", err_count, 3);
`endif

        // 4: status read held under rready low
        status_in[63:32] = 32'h12345678;
        bus.araddr  = 32'h24;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        check("t4_arready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("t4_rresp", bus.rresp, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("t4_rvalid", bus.rvalid, 1);
            check("t4_rdata", bus.rdata, 32'h12345678);
            check("t4_arready_low", bus.arready, 0);
            status_in[63:32] = 32'hA0000000 + 32'(i);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        check("t4_rvalid_clr", bus.rvalid, 0);
        check("t4_arready_back", bus.arready, 1);

        // 5: B stall with a second write waiting, read runs independently
        bus.bready  = 1'b0;
        bus.awaddr  = 32'h08;
        bus.wdata   = 32'h11111111;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge clk);
        exp_out[95:64] = 32'h11111111;
        check("t5_first_bvalid", bus.bvalid, 1);
        check("t5_first_reg", reg_out, exp_out);
        bus.awaddr = 32'h0C;
        bus.wdata  = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            check("t5_stall_ready", {bus.awready, bus.wready}, 0);
            check("t5_stall_bvalid", bus.bvalid, 1);
            if (i == 0) begin
                bus.araddr  = 32'h08;
                bus.arvalid = 1'b1;
                bus.rready  = 1'b1;
            end
            if (i == 1) begin
                bus.arvalid = 1'b0;
                check("t5_rd_rvalid", bus.rvalid, 1);
                check("t5_rd_rdata", bus.rdata, 32'h11111111);
                check("t5_rd_rresp", bus.rresp, 2'b00);
            end
            if (i == 2) check("t5_rd_done", bus.rvalid, 0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        check("t5_b_clr", bus.bvalid, 0);
        check("t5_ready_back", {bus.awready, bus.wready}, 2'b11);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        exp_out[127:96] = 32'h22222222;
        check("t5_second_bvalid", bus.bvalid, 1);
        check("t5_second_bresp", bus.bresp, 2'b00);
        check("t5_second_reg", reg_out, exp_out);
        check("t5_second_pulse", reg_wr_pulse, 8'b0000_1000);
        @(negedge clk);
        check("t5_second_clr", bus.bvalid, 0);

        // 6: reset while both responses are pending
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = 32'h10;
        bus.wdata   = 32'h55555555;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 32'h00;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        exp_out[159:128] = 32'h55555555;
        check("t6_pending", {bus.bvalid, bus.rvalid}, 2'b11);
        check("t6_reg_before", reg_out, exp_out);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valids", {bus.bvalid, bus.rvalid}, 0);
        check("t6_rst_reg_out", reg_out, 0);
        check("t6_rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        @(negedge clk);
        rst        = 1'b1;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        exp_out    = '0;
        do_write(32'h00, 32'h00000001, 4'hF, resp, pulse);
        exp_out[31:0] = 32'h00000001;
        check("t6_bresp", resp, 2'b00);
        check("t6_pulse", pulse, 8'b0000_0001);
        check("t6_reg_out", reg_out, exp_out);
        do_read(32'h00, rd, rr);
        check("t6_rd_rdata", rd, 32'h00000001);
        check("t6_rd_rresp", rr, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
